// File: rtl/grid_row_scanner.sv
// Scans a COLS x ROWS occupancy grid once per start pulse and reports which rows are completely filled.
// Optional macro SCANNER_TOP_OUT_EN enables row-0 occupancy tracking on top_out; otherwise top_out is tied low.
module grid_row_scanner #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            read_en,
  output logic [7:0]      address,
  input  logic [7:0]      block_data,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] full_rows,
  output logic [4:0]      full_count,
  output logic            top_out
);

  localparam int             CW        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int             RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [7:0]     LAST_ADDR = 8'(COLS * ROWS - 1);
  localparam logic [CW-1:0]  LAST_COL  = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic            valid_q, valid_d;       // block_data carries a cell this cycle
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            row_full_q, row_full_d;
  logic [ROWS-1:0] rows_q, rows_d;
  logic [ROWS-1:0] full_rows_q, full_rows_d;
  logic [4:0]      full_count_q, full_count_d;
`ifdef SCANNER_TOP_OUT_EN
  logic            top_q, top_d;
  logic            top_out_q, top_out_d;
`endif

  // NOTE: every signal written in an always_comb gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = READ;
      READ:  if (addr_q == LAST_ADDR) state_d = DRAIN;
      DRAIN: if (!valid_q) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_comb begin : datapath
    int unsigned ones;
    logic        occupied;
    logic        cell_full;
    addr_d       = (state_q == READ && addr_q != LAST_ADDR) ? addr_q + 8'd1 : 8'd0;
    valid_d      = (state_q == READ);
    col_d        = col_q;
    row_d        = row_q;
    row_full_d   = row_full_q;
    rows_d       = rows_q;
    full_rows_d  = full_rows_q;
    full_count_d = full_count_q;
    ones         = 0;
    occupied     = |block_data;
    cell_full    = row_full_q & occupied;
`ifdef SCANNER_TOP_OUT_EN
    top_d        = top_q;
    top_out_d    = top_out_q;
`endif

    if (state_q == IDLE && start) begin
      col_d      = '0;
      row_d      = '0;
      row_full_d = 1'b1;
      rows_d     = '0;
`ifdef SCANNER_TOP_OUT_EN
      top_d      = 1'b0;
`endif
    end

    // The read pipeline lags the address by one cycle; evaluation follows data, not address.
    if (valid_q) begin
      if (col_q == LAST_COL) begin
        rows_d[row_q] = cell_full;
        row_full_d    = 1'b1;
        col_d         = '0;
        row_d         = row_q + 1'b1;
      end else begin
        row_full_d    = cell_full;
        col_d         = col_q + 1'b1;
      end
`ifdef SCANNER_TOP_OUT_EN
      if (row_q == '0 && occupied) top_d = 1'b1;
`endif
    end

    if (state_q == DRAIN && state_d == DONE) begin
      full_rows_d = rows_q;
      for (int r = 0; r < ROWS; r++) ones += {31'd0, rows_q[r]};
      full_count_d = (ones > 31) ? 5'd31 : 5'(ones);
`ifdef SCANNER_TOP_OUT_EN
      top_out_d   = top_q;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      row_full_q   <= 1'b0;
      rows_q       <= '0;
      full_rows_q  <= '0;
      full_count_q <= '0;
`ifdef SCANNER_TOP_OUT_EN
      top_q        <= 1'b0;
      top_out_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_full_q   <= row_full_d;
      rows_q       <= rows_d;
      full_rows_q  <= full_rows_d;
      full_count_q <= full_count_d;
`ifdef SCANNER_TOP_OUT_EN
      top_q        <= top_d;
      top_out_q    <= top_out_d;
`endif
    end
  end

  assign read_en    = (state_q == READ);
  assign address    = read_en ? addr_q : 8'd0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign full_rows  = full_rows_q;
  assign full_count = full_count_q;
`ifdef SCANNER_TOP_OUT_EN
  assign top_out    = top_out_q;
`else
  assign top_out    = 1'b0;
`endif

endmodule

// File: tb/tb_grid_row_scanner.sv
// Self-checking bench for grid_row_scanner: a registered grid memory model feeds the scanner and
// a grid-level reference computes the expected row results directly from the memory contents.
module tb_grid_row_scanner;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int CELLS = COLS * ROWS;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            read_en;
  logic [7:0]      address;
  logic [7:0]      block_data = 8'd0;
  logic            busy;
  logic            done;
  logic [ROWS-1:0] full_rows;
  logic [4:0]      full_count;
  logic            top_out;

  logic [7:0]      mem [256];
  int              compared   = 0;
  int              mismatched = 0;
  logic [ROWS-1:0] held_rows  = '0;
  logic [4:0]      held_count = '0;
  logic            held_top   = 1'b0;

  grid_row_scanner #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .read_en    (read_en),
    .address    (address),
    .block_data (block_data),
    .busy       (busy),
    .done       (done),
    .full_rows  (full_rows),
    .full_count (full_count),
    .top_out    (top_out)
  );

  always #5 clk = ~clk;

  // Grid memory: data for a read appears in the cycle after read_en.
  always @(posedge clk) if (read_en) block_data <= mem[address];

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < COLS; c++) mem[r*COLS + c] = 8'($urandom_range(1, 255));
  endtask

  // Reference: a row is full when none of its cells is zero.
  task automatic model(output logic [ROWS-1:0] rows, output logic [4:0] count, output logic top);
    int n = 0;
    rows = '0;
    top  = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      bit full = 1'b1;
      for (int c = 0; c < COLS; c++) if (mem[r*COLS + c] == 8'd0) full = 1'b0;
      rows[r] = full;
      n += int'(full);
    end
    count = (n > 31) ? 5'd31 : 5'(n);
`ifdef SCANNER_TOP_OUT_EN
    for (int c = 0; c < COLS; c++) if (mem[c] != 8'd0) top = 1'b1;
`endif
  endtask

  task automatic run_scan(input string name, input bit repulse);
    logic [ROWS-1:0] exp_rows;
    logic [4:0]      exp_count;
    logic            exp_top;
    model(exp_rows, exp_count, exp_top);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k <= CELLS + 4; k++) begin
      logic       e_re, e_busy, e_done;
      logic [7:0] e_addr;
      e_re   = (k < CELLS);
      e_addr = e_re ? 8'(k) : 8'd0;
      e_busy = (k <= CELLS + 2);
      e_done = (k == CELLS + 2);
      compared++;
      if ({read_en, address, busy, done} !== {e_re, e_addr, e_busy, e_done}) begin
        mismatched++;
        $display("FAIL %s seq cyc=%0d: got re=%b addr=%0d busy=%b done=%b, want re=%b addr=%0d busy=%b done=%b",
                 name, k, read_en, address, busy, done, e_re, e_addr, e_busy, e_done);
      end
      if (k == CELLS + 2) begin
        compared += 3;
        if (full_rows !== exp_rows) begin
          mismatched++;
          $display("FAIL %s full_rows: got %h want %h", name, full_rows, exp_rows);
        end
        if (full_count !== exp_count) begin
          mismatched++;
          $display("FAIL %s full_count: got %0d want %0d", name, full_count, exp_count);
        end
        if (top_out !== exp_top) begin
          mismatched++;
          $display("FAIL %s top_out: got %b want %b", name, top_out, exp_top);
        end
        held_rows  = exp_rows;
        held_count = exp_count;
        held_top   = exp_top;
      end else if (k == 0 || k == 100 || k == CELLS + 1 || k == CELLS + 3) begin
        compared++;
        if ({full_rows, full_count, top_out} !== {held_rows, held_count, held_top}) begin
          mismatched++;
          $display("FAIL %s hold cyc=%0d: got rows=%h cnt=%0d top=%b want rows=%h cnt=%0d top=%b",
                   name, k, full_rows, full_count, top_out, held_rows, held_count, held_top);
        end
      end
      start = repulse && (k == 50 || k == CELLS + 2);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_idle_zero(input string name);
    compared++;
    if ({read_en, address, busy, done, full_rows, full_count, top_out} !== '0) begin
      mismatched++;
      $display("FAIL %s: got re=%b addr=%0d busy=%b done=%b rows=%h cnt=%0d top=%b want all zero",
               name, read_en, address, busy, done, full_rows, full_count, top_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset_state");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_zero("start_with_reset_ignored");
    held_rows = '0; held_count = '0; held_top = 1'b0;
  endtask

  task automatic test_empty();
    clear_mem();
    run_scan("empty", 1'b0);
  endtask

  task automatic test_two_full_rows();
    clear_mem();
    fill_row(19);
    fill_row(17);
    run_scan("rows_19_17", 1'b0);
  endtask

  task automatic test_row_missing();
    clear_mem();
    fill_row(5);
    mem[59] = 8'd0;
    run_scan("row5_missing", 1'b0);
  endtask

  task automatic test_top_cell();
    clear_mem();
    mem[3] = 8'($urandom_range(1, 255));
    run_scan("top_cell", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      clear_mem();
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 1) == 1) fill_row(r);
        else for (int c = 0; c < COLS; c++)
          mem[r*COLS + c] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      run_scan($sformatf("random%0d", it), 1'b0);
    end
  endtask

  task automatic test_restart_ignored();
    clear_mem();
    for (int r = 0; r < ROWS; r += 2) fill_row(r);
    run_scan("restart_ignored", 1'b1);
  endtask

  task automatic test_reset_midscan();
    int done_seen = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    compared++;
    if (address !== 8'd100) begin
      mismatched++;
      $display("FAIL midscan_addr: got %0d want 100", address);
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_midscan");
    reset = 1'b0;
    held_rows = '0; held_count = '0; held_top = 1'b0;
    for (int k = 0; k < CELLS + 10; k++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    compared++;
    if (done_seen != 0) begin
      mismatched++;
      $display("FAIL no_done_after_reset: got %0d busy/done cycles want 0", done_seen);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_empty();
    test_two_full_rows();
    test_reset_midscan();
    test_row_missing();
    test_top_cell();
    test_random();
    test_restart_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/grid_row_scanner.md
GRID_ROW_SCANNER -- requirements
Module: grid_row_scanner

Interface
REQ-001 SHALL have parameter COLS, default 10, meaning grid columns per row.
REQ-002 SHALL have parameter ROWS, default 20, meaning grid rows; the product COLS*ROWS SHALL be at most 256.
REQ-003 SHALL have port clk  input  1  meaning single system clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to scan the grid.
REQ-006 SHALL have port read_en  output  1  meaning grid memory read strobe.
REQ-007 SHALL have port address  output  8  meaning cell index, row*COLS+col, row 0 at top.
REQ-008 SHALL have port block_data  input  8  meaning cell contents, valid the cycle after read_en; nonzero means occupied.
REQ-009 SHALL have port busy  output  1  meaning a scan is in progress.
REQ-010 SHALL have port done  output  1  meaning a one-cycle pulse when the results are valid.
REQ-011 SHALL have port full_rows  output  ROWS  meaning bit r set when every cell of row r is occupied.
REQ-012 SHALL have port full_count  output  5  meaning the number of set bits in full_rows.
REQ-013 SHALL have port top_out  output  1  meaning some cell in row 0 is occupied (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-015 IDLE: start=1 sampled at an edge SHALL go to READ, set busy=1 and clear the internal row/column counters and accumulators.
REQ-016 READ: SHALL drive read_en=1 with address advancing by 1 each cycle from 0 to COLS*ROWS-1, one address per cycle, no gaps.
REQ-017 READ SHALL go to DRAIN on the edge after address COLS*ROWS-1 is presented.
REQ-018 SHALL evaluate block_data one cycle after each read: any zero cell SHALL clear the row-full flag for that row; after column COLS-1 the flag SHALL be written to the row's bit in an internal vector.
REQ-019 DRAIN: read_en=0; SHALL evaluate the final cell and then go to DONE.
REQ-020 DONE: done=1 for exactly one cycle; full_rows, full_count and top_out SHALL update on the edge entering DONE; SHALL return to IDLE with busy=0 at the next edge.
REQ-021 Latency SHALL be fixed: start sampled at edge 0 -> done high during the cycle after edge COLS*ROWS+2, which is edge 202 at the defaults.
REQ-022 full_rows, full_count and top_out SHALL hold their values until the next DONE; they SHALL NOT show partial results mid-scan.
REQ-023 start SHALL be ignored while busy=1, including in DONE.
REQ-024 address SHALL be 0 whenever read_en=0.
REQ-025 full_count SHALL saturate at 31 and never wrap; with ROWS<=20 it cannot overflow.

Reset
REQ-026 When reset=1, all state SHALL return to IDLE at the edge and outputs SHALL be: read_en=0, address=0, busy=0, done=0, full_rows=0, full_count=0, top_out=0.
REQ-027 reset mid-scan SHALL abort with no done pulse; start in the same cycle as reset SHALL be ignored.

Configuration
REQ-028 Macro SCANNER_TOP_OUT_EN defined: top_out SHALL be 1 after DONE if any row-0 cell read nonzero, else 0.
REQ-029 Macro SCANNER_TOP_OUT_EN undefined: the top_out port SHALL remain present, tied to 0, with no row-0 tracking logic.

Verification
REQ-030 Empty grid (all 0), start pulse -> read_en asserted for 200 consecutive cycles at addresses 0..199, done at edge 202, full_rows=0, full_count=0, top_out=0.
REQ-031 Rows 19 and 17 full, all other cells 0 -> full_rows=20'hA0000, full_count=2.
REQ-032 Row 5 full except address 59=0 -> full_rows bit 5=0, full_count=0.
REQ-033 Cell at address 3 nonzero -> top_out=1 with the macro defined, 0 without it.
REQ-034 reset asserted at address 100 -> next cycle read_en=0, busy=0, no done pulse; results from the previous scan cleared to 0.
REQ-035 start re-pulsed at addresses 50 and in DONE -> no restart, single done pulse, address sequence unbroken.
